// File: rtl/jk_pattern_bank.sv
// rtl/jk_pattern_bank.sv - JK register bank with J/K pattern memory and playback sequencer
// Optional JK_TICK_DIV_EN: replaces the tick port with an internal TICK_DIV prescaler.
module jk_pattern_bank #(
  parameter  int WIDTH    = 10,
  parameter  int DEPTH    = 4,
  parameter  int TICK_DIV = 8,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             preset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_j,
  input  logic [WIDTH-1:0] wr_k,
  input  logic             start,
  input  logic             loop,
  input  logic             tick,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    ptr,
  output logic [WIDTH-1:0] q
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic             loop_q, loop_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] mem_j_q [DEPTH];
  logic [WIDTH-1:0] mem_j_d [DEPTH];
  logic [WIDTH-1:0] mem_k_q [DEPTH];
  logic [WIDTH-1:0] mem_k_d [DEPTH];

  logic             tick_eff;
  logic             apply;
  logic [WIDTH-1:0] cur_j;
  logic [WIDTH-1:0] cur_k;

`ifdef JK_TICK_DIV_EN
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] div_q, div_d;
  logic          unused_tick;

  assign unused_tick = tick;

  // Counter idles at zero outside RUN so the first tick lands TICK_DIV cycles after busy rises.
  always_comb begin
    tick_eff = (state_q == ST_RUN) && (div_q == CW'(TICK_DIV - 1));
    div_d    = '0;
    if (state_q == ST_RUN && !tick_eff) begin
      div_d = div_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end
`else
  assign tick_eff = tick;
`endif

  // The applied entry is read from the registered memory, so a same-cycle write lands afterwards.
  assign cur_j = mem_j_q[ptr_q];
  assign cur_k = mem_k_q[ptr_q];
  assign apply = (state_q == ST_RUN) && tick_eff;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    loop_d  = loop_q;
    q_d     = q_q;
    mem_j_d = mem_j_q;
    mem_k_d = mem_k_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          ptr_d   = '0;
          loop_d  = loop;
        end
      end
      ST_RUN: begin
        if (tick_eff) begin
          if (ptr_q == AW'(DEPTH - 1)) begin
            ptr_d = '0;
            if (!loop_q) begin
              state_d = ST_DONE;
            end
          end else begin
            ptr_d = ptr_q + AW'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (preset) begin
      q_d = '1;
    end else if (apply) begin
      q_d = (cur_j & ~q_q) | (~cur_k & q_q);
    end

    if (wr_en) begin
      mem_j_d[wr_addr] = wr_j;
      mem_k_d[wr_addr] = wr_k;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      loop_q  <= 1'b0;
      q_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_j_q[i] <= '0;
        mem_k_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      loop_q  <= loop_d;
      q_q     <= q_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_j_q[i] <= mem_j_d[i];
        mem_k_q[i] <= mem_k_d[i];
      end
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign ptr  = ptr_q;
  assign q    = q_q;

endmodule
